// File: rtl/pixel_stream_source.sv
// Raster pixel source: reads an IMG_W x IMG_H frame from a 1-cycle BRAM
// and streams it out one pixel per cycle, with optional line blanking.
//
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   start, num_frames     begin streaming; frame count (0 = continuous)
//   abort                 stop streaming at the next edge
//   mem_rd_en, mem_addr   registered BRAM read strobe and address
//   mem_rdata             BRAM data, valid the cycle after mem_rd_en
//   data, data_valid      pixel stream to downstream
//   frame_done            pulse alongside the last pixel of each frame
//   busy                  high from start acceptance until stream end
module pixel_stream_source #(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int ADDR_W = 14,
    parameter int HBLANK = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              start,
    input  logic [7:0]        num_frames,
    input  logic              abort,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              frame_done,
    output logic              busy
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [7:0]        BLANK_LAST = 8'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam bit                HAS_BLANK  = (HBLANK > 0);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        BLANK,
        FLUSH
    } state_t;

    state_t            state;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [7:0]        frame_cnt;
    logic [7:0]        nf_lat;
    logic [7:0]        blank_cnt;
    logic [DATA_W-1:0] data_hold;

    logic line_end;
    logic frame_end;
    logic last_frame;

    assign line_end   = (col == COL_LAST);
    assign frame_end  = line_end && (row == ROW_LAST);
    assign last_frame = (nf_lat != 8'd0) && ((frame_cnt + 8'd1) == nf_lat);

    // The returning BRAM word is presented directly in its valid cycle
    // and captured so the output holds it while data_valid is low.
    assign data = data_valid ? mem_rdata : data_hold;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            frame_cnt  <= '0;
            nf_lat     <= '0;
            blank_cnt  <= '0;
            data_hold  <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            data_valid <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= mem_rd_en;
            frame_done <= mem_rd_en && (mem_addr == LAST_ADDR);
            if (data_valid) begin
                data_hold <= mem_rdata;
            end

            if (abort) begin
                // A read already issued still returns; nothing new starts.
                mem_rd_en <= 1'b0;
                if (state == ACTIVE || state == BLANK) begin
                    state <= FLUSH;
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            state     <= ACTIVE;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= '0;
                            col       <= '0;
                            row       <= '0;
                            frame_cnt <= '0;
                            blank_cnt <= '0;
                            nf_lat    <= num_frames;
                        end
                    end
                    ACTIVE: begin
                        mem_addr <= frame_end ? '0 : mem_addr + ADDR_W'(1);
                        col      <= line_end ? '0 : col + COL_W'(1);
                        if (line_end) begin
                            row <= frame_end ? '0 : row + ROW_W'(1);
                        end
                        if (frame_end) begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                        if (frame_end && last_frame) begin
                            state     <= FLUSH;
                            mem_rd_en <= 1'b0;
                        end else if (HAS_BLANK && line_end) begin
                            state     <= BLANK;
                            mem_rd_en <= 1'b0;
                            blank_cnt <= '0;
                        end else begin
                            mem_rd_en <= 1'b1;
                        end
                    end
                    BLANK: begin
                        if (blank_cnt == BLANK_LAST) begin
                            state     <= ACTIVE;
                            mem_rd_en <= 1'b1;
                        end else begin
                            blank_cnt <= blank_cnt + 8'd1;
                        end
                    end
                    FLUSH: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
